// File: rtl/axi_burst_splitter.sv
// Replays upstream AXI bursts (FIXED/INCR/WRAP, LN 0..255) as single-beat transactions
// to a single-beat slave; write responses are merged into one B, read beats get RID/RLAST regenerated.
module axi_burst_splitter #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_MASK_WIDTH = AXI_DATA_WIDTH / 8
) (
    input  logic                      CPUNC_ACLK,
    input  logic                      CPUNC_ARESET,
    input  logic [7:0]                S_AWID,
    input  logic [AXI_ADDR_WIDTH-1:0] S_AWADDR,
    input  logic [7:0]                S_AWLN,
    input  logic [1:0]                S_AWBURST,
    input  logic                      S_AWVALID,
    output logic                      S_AWREADY,
    input  logic [AXI_DATA_WIDTH-1:0] S_WDATA,
    input  logic [AXI_MASK_WIDTH-1:0] S_WSTRB,
    input  logic                      S_WLAST,
    input  logic                      S_WVALID,
    output logic                      S_WREADY,
    output logic [7:0]                S_BID,
    output logic                      S_BRESP,
    output logic                      S_BVALID,
    input  logic                      S_BREADY,
    input  logic [7:0]                S_ARID,
    input  logic [AXI_ADDR_WIDTH-1:0] S_ARADDR,
    input  logic [7:0]                S_ARLN,
    input  logic [1:0]                S_ARBURST,
    input  logic                      S_ARVALID,
    output logic                      S_ARREADY,
    output logic [7:0]                S_RID,
    output logic [AXI_DATA_WIDTH-1:0] S_RDATA,
    output logic                      S_RRESP,
    output logic                      S_RLAST,
    output logic                      S_RVALID,
    input  logic                      S_RREADY,
    output logic [7:0]                M_AWID,
    output logic [AXI_ADDR_WIDTH-1:0] M_AWADDR,
    output logic [7:0]                M_AWLN,
    output logic                      M_AWVALID,
    input  logic                      M_AWREADY,
    output logic [AXI_DATA_WIDTH-1:0] M_WDATA,
    output logic [AXI_MASK_WIDTH-1:0] M_WSTRB,
    output logic                      M_WLAST,
    output logic                      M_WVALID,
    input  logic                      M_WREADY,
    input  logic                      M_BRESP,
    input  logic                      M_BVALID,
    output logic                      M_BREADY,
    output logic [7:0]                M_ARID,
    output logic [AXI_ADDR_WIDTH-1:0] M_ARADDR,
    output logic [7:0]                M_ARLN,
    output logic                      M_ARVALID,
    input  logic                      M_ARREADY,
    input  logic [AXI_DATA_WIDTH-1:0] M_RDATA,
    input  logic                      M_RRESP,
    input  logic                      M_RVALID,
    output logic                      M_RREADY
);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef enum logic [2:0] {W_IDLE, W_AADDR, W_WDATA, W_WRESP, W_BRSP, W_SINK} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_RADDR, R_RDATA, R_RSVD} r_state_t;

    w_state_t                  w_state;
    logic [7:0]                w_id;
    logic [AXI_ADDR_WIDTH-1:0] w_addr;
    logic [7:0]                w_ln;
    logic [1:0]                w_burst;
    logic [7:0]                w_cnt;
    logic                      w_err;

    r_state_t                  r_state;
    logic [7:0]                r_id;
    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [7:0]                r_ln;
    logic [1:0]                r_burst;
    logic [7:0]                r_cnt;

    // Beat address step; INCR never leaves its 4 KB page, WRAP stays in its (LN+1)*4 window.
    function automatic logic [AXI_ADDR_WIDTH-1:0] next_addr(
        input logic [AXI_ADDR_WIDTH-1:0] addr,
        input logic [7:0]                ln,
        input logic [1:0]                burst
    );
        logic [AXI_ADDR_WIDTH-1:0] incr_4k;
        logic [AXI_ADDR_WIDTH-1:0] mask;
        logic [AXI_ADDR_WIDTH-1:0] wrapped;
        incr_4k = {addr[AXI_ADDR_WIDTH-1:12], addr[11:0] + 12'd4};
        mask    = {{(AXI_ADDR_WIDTH-10){1'b0}}, ln, 2'b11};
        wrapped = (addr & ~mask) | ((addr + AXI_ADDR_WIDTH'(4)) & mask);
        if (burst == BURST_FIXED) begin
            return addr;
        end else if (burst == BURST_WRAP &&
                     (ln == 8'd1 || ln == 8'd3 || ln == 8'd7 || ln == 8'd15)) begin
            return wrapped;
        end
        return incr_4k;
    endfunction

    always_ff @(posedge CPUNC_ACLK) begin
        if (CPUNC_ARESET) begin
            w_state <= W_IDLE;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (S_AWVALID) begin
                        w_id    <= S_AWID;
                        w_addr  <= S_AWADDR;
                        w_ln    <= S_AWLN;
                        w_burst <= S_AWBURST;
                        w_cnt   <= 8'd0;
                        w_err   <= (S_AWBURST == BURST_RSVD);
                        w_state <= (S_AWBURST == BURST_RSVD) ? W_SINK : W_AADDR;
                    end
                end
                W_AADDR: begin
                    if (M_AWREADY) w_state <= W_WDATA;
                end
                W_WDATA: begin
                    if (S_WVALID && M_WREADY) begin
                        if (S_WLAST != (w_cnt == w_ln)) w_err <= 1'b1;
                        w_state <= W_WRESP;
                    end
                end
                W_WRESP: begin
                    if (M_BVALID) begin
                        if (M_BRESP) w_err <= 1'b1;
                        if (w_cnt == w_ln) begin
                            w_state <= W_BRSP;
                        end else begin
                            w_cnt   <= w_cnt + 8'd1;
                            w_addr  <= next_addr(w_addr, w_ln, w_burst);
                            w_state <= W_AADDR;
                        end
                    end
                end
                W_SINK: begin
                    if (S_WVALID) begin
                        if (w_cnt == w_ln) w_state <= W_BRSP;
                        else               w_cnt   <= w_cnt + 8'd1;
                    end
                end
                W_BRSP: begin
                    if (S_BREADY) w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge CPUNC_ACLK) begin
        if (CPUNC_ARESET) begin
            r_state <= R_IDLE;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (S_ARVALID) begin
                        r_id    <= S_ARID;
                        r_addr  <= S_ARADDR;
                        r_ln    <= S_ARLN;
                        r_burst <= S_ARBURST;
                        r_cnt   <= 8'd0;
                        r_state <= (S_ARBURST == BURST_RSVD) ? R_RSVD : R_RADDR;
                    end
                end
                R_RADDR: begin
                    if (M_ARREADY) r_state <= R_RDATA;
                end
                R_RDATA: begin
                    if (M_RVALID && S_RREADY) begin
                        if (r_cnt == r_ln) begin
                            r_state <= R_IDLE;
                        end else begin
                            r_cnt   <= r_cnt + 8'd1;
                            r_addr  <= next_addr(r_addr, r_ln, r_burst);
                            r_state <= R_RADDR;
                        end
                    end
                end
                R_RSVD: begin
                    if (S_RREADY) begin
                        if (r_cnt == r_ln) r_state <= R_IDLE;
                        else               r_cnt   <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Handshake signals are pure state decodes plus the opposite side's ready/valid.
    assign S_AWREADY = (w_state == W_IDLE);
    assign M_AWVALID = (w_state == W_AADDR);
    assign M_AWID    = w_id;
    assign M_AWADDR  = w_addr;
    assign M_AWLN    = 8'd0;
    assign M_WVALID  = (w_state == W_WDATA) && S_WVALID;
    assign M_WDATA   = S_WDATA;
    assign M_WSTRB   = S_WSTRB;
    assign M_WLAST   = 1'b1;
    assign S_WREADY  = ((w_state == W_WDATA) && M_WREADY) || (w_state == W_SINK);
    assign M_BREADY  = (w_state == W_WRESP);
    assign S_BVALID  = (w_state == W_BRSP);
    assign S_BID     = w_id;
    assign S_BRESP   = w_err;

    assign S_ARREADY = (r_state == R_IDLE);
    assign M_ARVALID = (r_state == R_RADDR);
    assign M_ARID    = r_id;
    assign M_ARADDR  = r_addr;
    assign M_ARLN    = 8'd0;
    assign M_RREADY  = (r_state == R_RDATA) && S_RREADY;
    assign S_RVALID  = ((r_state == R_RDATA) && M_RVALID) || (r_state == R_RSVD);
    assign S_RID     = r_id;
    assign S_RDATA   = (r_state == R_RDATA) ? M_RDATA : '0;
    assign S_RRESP   = (r_state == R_RDATA) ? M_RRESP : 1'b1;
    assign S_RLAST   = (r_cnt == r_ln);

endmodule
